// File: rtl/target_port.sv
// Bus-side front end for the 8-bit memory target: serial bus <-> parallel target strobes.
// Optional WAIT-state response timeout is enabled with `define TARGET_PORT_TIMEOUT_EN.
module target_port #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              b_sel,
    input  logic              b_valid,
    input  logic              b_wdata,
    input  logic              b_mode,
    output logic              b_rdata,
    output logic              b_rvalid,
    output logic              b_ack,
    output logic              b_err,
    output logic              b_ready,
    output logic [ADDR_W-1:0] t_addr,
    output logic              t_addr_valid,
    output logic [DATA_W-1:0] t_wdata,
    output logic              t_wdata_valid,
    output logic              t_rw,
    input  logic [DATA_W-1:0] t_rdata,
    input  logic              t_rdata_valid,
    input  logic              t_ack,
    input  logic              t_ready
);

    localparam int MAXW  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAXW + 1);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, ISSUE, WAIT, RDATA} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              mode_q;
    logic              b_rdata_q, b_rvalid_q, b_ack_q;
    logic [ADDR_W-1:0] t_addr_q;
    logic [DATA_W-1:0] t_wdata_q;
    logic              t_addr_valid_q, t_wdata_valid_q, t_rw_q;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_d;

    // Serial bits arrive LSB first, so shifting in from the top leaves bit 0 at the bottom.
    assign addr_d = {b_wdata, addr_q[ADDR_W-1:1]};
    assign data_d = {b_wdata, data_q[DATA_W-1:1]};

`ifdef TARGET_PORT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wait_cnt_q;
    logic          b_err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            addr_q          <= '0;
            data_q          <= '0;
            mode_q          <= 1'b0;
            b_rdata_q       <= 1'b0;
            b_rvalid_q      <= 1'b0;
            b_ack_q         <= 1'b0;
            t_addr_q        <= '0;
            t_wdata_q       <= '0;
            t_addr_valid_q  <= 1'b0;
            t_wdata_valid_q <= 1'b0;
            t_rw_q          <= 1'b0;
`ifdef TARGET_PORT_TIMEOUT_EN
            wait_cnt_q      <= '0;
            b_err_q         <= 1'b0;
`endif
        end else begin
            b_ack_q         <= 1'b0;
            t_addr_valid_q  <= 1'b0;
            t_wdata_valid_q <= 1'b0;
`ifdef TARGET_PORT_TIMEOUT_EN
            b_err_q         <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (b_sel && b_valid && t_ready) begin
                        addr_q  <= addr_d;
                        mode_q  <= b_mode;
                        cnt_q   <= CNT_W'(1);
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (!b_sel) begin
                        state_q <= IDLE;
                    end else if (b_valid) begin
                        addr_q <= addr_d;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                            if (mode_q) begin
                                cnt_q   <= '0;
                                state_q <= WDATA;
                            end else begin
                                t_addr_q       <= addr_d;
                                t_rw_q         <= 1'b0;
                                t_addr_valid_q <= 1'b1;
                                state_q        <= ISSUE;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (!b_sel) begin
                        state_q <= IDLE;
                    end else if (b_valid) begin
                        data_q <= data_d;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            t_addr_q        <= addr_q;
                            t_wdata_q       <= data_d;
                            t_rw_q          <= 1'b1;
                            t_addr_valid_q  <= 1'b1;
                            t_wdata_valid_q <= 1'b1;
                            state_q         <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
`ifdef TARGET_PORT_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                end
                WAIT: begin
                    if (mode_q && t_ack) begin
                        b_ack_q <= 1'b1;
                        state_q <= IDLE;
                    end else if (!mode_q && t_rdata_valid) begin
                        // Bit 0 goes out immediately; the rest drain from the shift register.
                        b_rdata_q  <= t_rdata[0];
                        b_rvalid_q <= 1'b1;
                        data_q     <= t_rdata >> 1;
                        cnt_q      <= CNT_W'(1);
                        state_q    <= RDATA;
`ifdef TARGET_PORT_TIMEOUT_EN
                    end else if (wait_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                        b_ack_q <= 1'b1;
                        b_err_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + TW'(1);
`endif
                    end
                end
                RDATA: begin
                    if (cnt_q == CNT_W'(DATA_W)) begin
                        b_rdata_q  <= 1'b0;
                        b_rvalid_q <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        b_rdata_q <= data_q[0];
                        data_q    <= data_q >> 1;
                        cnt_q     <= cnt_q + CNT_W'(1);
                        b_ack_q   <= (cnt_q == CNT_W'(DATA_W - 1));
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign b_ready       = (state_q == IDLE) && t_ready;
    assign b_rdata       = b_rdata_q;
    assign b_rvalid      = b_rvalid_q;
    assign b_ack         = b_ack_q;
    assign t_addr        = t_addr_q;
    assign t_wdata       = t_wdata_q;
    assign t_addr_valid  = t_addr_valid_q;
    assign t_wdata_valid = t_wdata_valid_q;
    assign t_rw          = t_rw_q;
`ifdef TARGET_PORT_TIMEOUT_EN
    assign b_err         = b_err_q;
`else
    assign b_err         = 1'b0;
`endif

endmodule

// File: doc/target_port.md
Name: target_port

Overview:
- Bus-side front end for the 8-bit memory target; sits directly upstream of it on the dual serial bus.
- Deserialises bit-serial address/mode/write-data from the bus into the target's parallel single-cycle strobes (address, data, rw).
- Captures the target's parallel read data or ack and returns it to the bus: read data bit-serially, plus a completion pulse.

Parameters:
- ADDR_W, 16, serial address length in bits (>=2); full width driven on t_addr.
- DATA_W, 8, data width in bits (>=2).
- TIMEOUT_CYC, 15, response-wait limit in cycles; used only with TARGET_PORT_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- b_sel  in  1  target selected by bus decoder
- b_valid  in  1  serial bit qualifier
- b_wdata  in  1  serial address/write-data bit, LSB first
- b_mode  in  1  1=write, 0=read; sampled with first address bit
- b_rdata  out  1  serial read-data bit, LSB first
- b_rvalid  out  1  b_rdata qualifier
- b_ack  out  1  one-cycle transaction-complete pulse
- b_err  out  1  one-cycle timeout pulse, coincident with b_ack
- b_ready  out  1  (state==IDLE) && t_ready, combinational
- t_addr  out  ADDR_W  parallel address to target
- t_addr_valid  out  1  address strobe
- t_wdata  out  DATA_W  parallel write data
- t_wdata_valid  out  1  write-data strobe
- t_rw  out  1  1=write
- t_rdata  in  DATA_W  target read data
- t_rdata_valid  in  1  target read-data strobe
- t_ack  in  1  target ack
- t_ready  in  1  target ready

Behaviour:
- Reset: state IDLE; all registered outputs 0 (b_rdata, b_rvalid, b_ack, b_err, t_addr, t_addr_valid, t_wdata, t_wdata_valid, t_rw); bit counter and shift registers 0. Reset mid-transaction discards it; no strobe is issued afterwards.
- A bit is accepted only on a clock edge with b_sel && b_valid. Gaps with b_valid=0 are legal and hold state and counter.
- IDLE:
  - Entry requires t_ready.
  - An accepted bit becomes addr[0]; b_mode is latched; cnt=1 -> ADDR.
- ADDR:
  - Each accepted bit is stored at addr[cnt]; cnt increments.
  - On bit ADDR_W-1: write -> WDATA (cnt=0); read -> ISSUE.
- WDATA: collects DATA_W bits LSB first; the last bit moves to ISSUE.
- Abort: b_sel=0 in ADDR or WDATA -> IDLE next edge. No target strobe, no b_ack.
- ISSUE, exactly one cycle:
  - t_addr_valid=1, t_addr=addr, t_rw=mode.
  - For writes, t_wdata_valid=1 and t_wdata=data in the same cycle. For reads, t_wdata_valid=0.
  - Then WAIT.
- Strobe timing: if the last bit is sampled at edge E0, strobes are high E0->E1.
- WAIT:
  - Write: t_ack -> b_ack=1 for one cycle (E2->E3 with a single-cycle-latency target), then IDLE.
  - Read: t_rdata_valid -> load shift register from t_rdata -> RDATA.
  - t_ack without t_rdata_valid during a read is ignored.
  - Response inputs are ignored in all other states.
- RDATA:
  - b_rvalid=1 for DATA_W consecutive cycles, b_rdata=bit i in cycle i.
  - b_ack pulses with the last bit, then IDLE. b_sel is ignored in this state.
- b_ready=0 outside IDLE. New bits are ignored until back in IDLE.

Optional Feature:
- TARGET_PORT_TIMEOUT_EN defined:
  - A WAIT counter starts at 0 on entry and increments each cycle.
  - If no qualifying response arrives by TIMEOUT_CYC cycles, b_ack=1 and b_err=1 for one cycle, then IDLE.
  - For a timed-out read, b_rvalid stays 0.
  - A response arriving in the same cycle as the timeout wins; no error is raised.
- Undefined: WAIT waits indefinitely; b_err is tied to 0.

Test Plan:
- Write: addr 0x0005, mode=1, data 0xA3, contiguous bits -> one-cycle t_addr_valid and t_wdata_valid with t_addr=0x0005, t_wdata=0xA3, t_rw=1; b_ack 2 cycles after the strobe.
- Read back 0x0005 -> t_rw=0, t_wdata_valid=0; b_rvalid 8 cycles with b_rdata 1,1,0,0,0,1,0,1; b_ack with the final bit.
- Write addr 0x000F, data 0x5C, b_valid toggling every other cycle -> identical strobes (t_addr=0x000F, t_wdata=0x5C), no extra strobes.
- b_sel drops after 7 address bits -> no t_addr_valid, no b_ack, b_ready=1 next cycle; a following write 0x0002/0x11 completes normally.
- rst_n asserted during the 4th read-data bit -> all outputs 0 immediately; state IDLE; no b_ack after release.
- Macro defined, stub target never acks a write -> b_ack=b_err=1 exactly TIMEOUT_CYC (15) cycles after WAIT entry. Macro undefined -> b_ack never asserts.
